// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hazard and sequencing controller.
// Drives stall/flush controls for the PC, F/D and D/E registers. It handles
// taken branches resolved in E, load-use hazards between D and E, and
// serializing instructions that must drain older work before they issue.
// It also keeps the stall-cycle and branch-flush performance counters.
module pipeline_hazard_ctrl #(
  parameter int unsigned LU_STALL_CYCLES = 1,
  parameter int unsigned BR_FLUSH_CYCLES = 1,
  parameter int unsigned DRAIN_CYCLES    = 3,
  parameter int unsigned CNT_W           = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [4:0]       rs1_d_i,
  input  logic [4:0]       rs2_d_i,
  input  logic             rs1_used_d_i,
  input  logic             rs2_used_d_i,
  input  logic             serial_d_i,
  input  logic [4:0]       rd_e_i,
  input  logic             regwen_e_i,
  input  logic             memread_e_i,
  input  logic             pcsel_e_i,
  input  logic             cnt_clr_i,
  output logic             pc_stop_o,
  output logic             fd_flush_o,
  output logic             de_flush_o,
  output logic             de_nop_o,
  output logic [1:0]       state_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o
);

  typedef enum logic [1:0] {
    StRun     = 2'd0,
    StLuStall = 2'd1,
    StBrFlush = 2'd2,
    StDrain   = 2'd3
  } state_e;

  // rem only ever holds (cycles - 1), so $clog2 of the largest count is enough.
  localparam int unsigned MaxLuBr    = (LU_STALL_CYCLES > BR_FLUSH_CYCLES) ?
                                       LU_STALL_CYCLES : BR_FLUSH_CYCLES;
  localparam int unsigned MaxCycles  = (MaxLuBr > DRAIN_CYCLES) ? MaxLuBr : DRAIN_CYCLES;
  localparam int unsigned RemW       = (MaxCycles > 1) ? $clog2(MaxCycles) : 1;

  localparam logic [RemW-1:0] LuRem  = RemW'(LU_STALL_CYCLES - 1);
  localparam logic [RemW-1:0] BrRem  = RemW'(BR_FLUSH_CYCLES - 1);
  localparam logic [RemW-1:0] DrRem  = RemW'(DRAIN_CYCLES - 1);
  localparam logic [RemW-1:0] RemOne = RemW'(1);

  state_e          state_q, state_d;
  logic [RemW-1:0] rem_q, rem_d;
  logic            drained_q, drained_d;
  logic            lu_haz;

  logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;
  logic             stall_inc, flush_inc;

  // Load-use: E is a load writing a nonzero rd that D reads.
  always_comb begin
    lu_haz = memread_e_i & regwen_e_i & (rd_e_i != 5'd0) &
             ((rs1_used_d_i & (rs1_d_i == rd_e_i)) |
              (rs2_used_d_i & (rs2_d_i == rd_e_i)));
  end

  // State register: FSM state, remaining-cycle counter and drained flag.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= StRun;
      rem_q     <= '0;
      drained_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      rem_q     <= rem_d;
      drained_q <= drained_d;
    end
  end

  // Next-state logic; a taken branch overrides everything in every state.
  always_comb begin
    state_d   = state_q;
    rem_d     = rem_q;
    drained_d = drained_q;
    if (pcsel_e_i) begin
      // The D instruction is wrong-path, so any pending drain is void.
      drained_d = 1'b0;
      if (BR_FLUSH_CYCLES > 1) begin
        state_d = StBrFlush;
        rem_d   = BrRem;
      end else begin
        state_d = StRun;
        rem_d   = '0;
      end
    end else begin
      unique case (state_q)
        StRun: begin
          if (lu_haz) begin
            if (LU_STALL_CYCLES > 1) begin
              state_d = StLuStall;
              rem_d   = LuRem;
            end
          end else if (serial_d_i && !drained_q) begin
            if (DRAIN_CYCLES > 1) begin
              state_d = StDrain;
              rem_d   = DrRem;
            end else begin
              drained_d = 1'b1;
            end
          end else begin
            // D advances this cycle, so the drain credit is consumed.
            drained_d = 1'b0;
          end
        end
        StLuStall, StBrFlush: begin
          rem_d = rem_q - RemOne;
          if (rem_q == RemOne) begin
            state_d = StRun;
          end
        end
        StDrain: begin
          rem_d = rem_q - RemOne;
          if (rem_q == RemOne) begin
            state_d   = StRun;
            drained_d = 1'b1;
          end
        end
      endcase
    end
  end

  // Mealy output decode; reset forces a flush of F/D and D/E.
  always_comb begin
    pc_stop_o  = 1'b0;
    fd_flush_o = 1'b0;
    de_flush_o = 1'b0;
    de_nop_o   = 1'b0;
    if (rst_i) begin
      fd_flush_o = 1'b1;
      de_flush_o = 1'b1;
    end else if (pcsel_e_i) begin
      fd_flush_o = 1'b1;
      de_flush_o = 1'b1;
    end else begin
      unique case (state_q)
        StRun: begin
          if (lu_haz || (serial_d_i && !drained_q)) begin
            pc_stop_o = 1'b1;
            de_nop_o  = 1'b1;
          end
        end
        StLuStall, StDrain: begin
          pc_stop_o = 1'b1;
          de_nop_o  = 1'b1;
        end
        StBrFlush: begin
          fd_flush_o = 1'b1;
          de_flush_o = 1'b1;
        end
      endcase
    end
  end

  always_comb begin
    state_o   = state_q;
    stall_inc = pc_stop_o & ~fd_flush_o;
    flush_inc = pcsel_e_i;
  end

  // Performance counters; clear wins over the same cycle's increment.
  always_ff @(posedge clk_i) begin
    if (rst_i || cnt_clr_i) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (stall_inc) begin
        stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      end
      if (flush_inc) begin
        flush_cnt_q <= flush_cnt_q + CNT_W'(1);
      end
    end
  end

  assign stall_cnt_o = stall_cnt_q;
  assign flush_cnt_o = flush_cnt_q;

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
Central hazard and sequencing controller for the 5-stage pipeline. It drives the stall and flush controls of the PC, F/D and D/E pipeline registers, and handles three hazard sources: taken branch/jump resolved in E, load-use dependency between D and E, and serializing instructions (fence, fence.i, csr) that must drain older instructions first. It also keeps stall and flush performance counters.

Parameters:
LU_STALL_CYCLES, 1, bubbles inserted per load-use hazard (>=1)
BR_FLUSH_CYCLES, 1, cycles of F/D+D/E flush per taken branch (>=1)
DRAIN_CYCLES, 3, stall cycles before a serializing instruction issues (>=1)
CNT_W, 32, width of performance counters

Ports:
clk_i  in  1  clock, all state on rising edge
rst_i  in  1  synchronous active-high reset
rs1_d_i  in  5  rs1 index of instruction in D
rs2_d_i  in  5  rs2 index of instruction in D
rs1_used_d_i  in  1  D instruction reads rs1
rs2_used_d_i  in  1  D instruction reads rs2
serial_d_i  in  1  D instruction is serializing
rd_e_i  in  5  rd index of instruction in E
regwen_e_i  in  1  E instruction writes rd (RegWEn from D/E)
memread_e_i  in  1  E instruction is a load (WBSel = mem)
pcsel_e_i  in  1  E redirects PC (PCSel from D/E)
cnt_clr_i  in  1  clear both counters
pc_stop_o  out  1  hold PC and F/D register
fd_flush_o  out  1  F/D loads NOP
de_flush_o  out  1  D/E loads bubble (to pipeline_flush_i)
de_nop_o  out  1  D/E loads bubble for stall (to pipeline_nop_i)
state_o  out  2  current state: 0 RUN, 1 LU_STALL, 2 BR_FLUSH, 3 DRAIN
stall_cnt_o  out  CNT_W  stall cycle count
flush_cnt_o  out  CNT_W  branch flush event count

Behaviour:
- Interface: single clock clk_i. rst_i is synchronous and active-high.
- Control outputs are a combinational (Mealy) decode of the state register and the current inputs. The state register, the down-counter rem, the drained flag and the counters are registered.
- Reset (rst_i=1 at an edge): state=RUN, rem=0, drained=0, both counters=0.
- While rst_i=1, outputs are forced: fd_flush_o=1, de_flush_o=1, pc_stop_o=0, de_nop_o=0.
- lu_haz = memread_e_i & regwen_e_i & (rd_e_i!=0) & ((rs1_used_d_i & rs1_d_i==rd_e_i) | (rs2_used_d_i & rs2_d_i==rd_e_i)).
- RUN, priority order:
  - pcsel_e_i: fd_flush_o=1, de_flush_o=1, pc_stop_o=0. flush_cnt +1. drained cleared. If BR_FLUSH_CYCLES>1, go to BR_FLUSH with rem=BR_FLUSH_CYCLES-1.
  - else lu_haz: pc_stop_o=1, de_nop_o=1. If LU_STALL_CYCLES>1, go to LU_STALL with rem=LU_STALL_CYCLES-1.
  - else serial_d_i & !drained: pc_stop_o=1, de_nop_o=1. Go to DRAIN with rem=DRAIN_CYCLES-1. If DRAIN_CYCLES=1, set drained and stay in RUN.
  - else all control outputs 0. drained is cleared on this cycle, because D advances.
- LU_STALL: pc_stop_o=1, de_nop_o=1. Decrement rem. When rem==1, return to RUN.
- BR_FLUSH: fd_flush_o=1, de_flush_o=1. Decrement rem. When rem==1, return to RUN.
- DRAIN: pc_stop_o=1, de_nop_o=1. Decrement rem. When rem==1, return to RUN and set drained=1. The serializing instruction then issues once without re-triggering.
- Any non-RUN state with pcsel_e_i=1 behaves as a branch:
  - flush outputs asserted, pc_stop_o=0, flush_cnt +1;
  - rem is reloaded from BR_FLUSH_CYCLES exactly as in RUN;
  - drained is cleared.
  - This is defensive; E holds bubbles in these states.
- Simultaneous hazards: branch beats load-use and serialize, because the D instruction is wrong-path. Load-use beats serialize.
- stall_cnt: +1 every cycle with pc_stop_o=1 and fd_flush_o=0.
- Counters wrap modulo 2^CNT_W. cnt_clr_i zeroes both counters next edge and overrides that cycle's increment.
- Reset mid-stall or mid-flush returns to RUN immediately. No residual stall after rst_i deasserts.

Test Plan:
- Reset: hold rst_i=1 for 2 cycles -> fd_flush_o=de_flush_o=1, pc_stop_o=0, state_o=0, counters 0.
- Load-use, defaults: memread_e=1, regwen_e=1, rd_e=5, rs1_d=5, rs1_used=1 -> exactly 1 cycle pc_stop_o=de_nop_o=1, stall_cnt=1. With rd_e=0 -> no stall.
- Branch + load-use same cycle: pcsel_e=1 with lu_haz true -> fd_flush_o=de_flush_o=1, pc_stop_o=0, flush_cnt=1, stall_cnt unchanged.
- Serialize, DRAIN_CYCLES=3: serial_d=1 held -> pc_stop_o=1 for 3 cycles (state_o=3 on cycles 2-3), then one cycle with all outputs 0, stall_cnt=3.
- Reset mid-drain: rst_i on drain cycle 2 -> next cycle state_o=0, pc_stop_o=0 once rst_i is low.
- Counter wrap and clear: preload stall_cnt to 2^32-1, stall one cycle -> 0. cnt_clr_i together with a stall -> 0.
